// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame sequencer: state encoding,
// output-mux select codes and small sizing/decoding helpers.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // A single-bit frame still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Idle shares the stop code: both drive a high line.
  function automatic logic [1:0] mux_for_state(input tx_state_e state);
    logic [1:0] sel;
    sel = MUX_STOP;
    case (state)
      START:   sel = MUX_START;
      DATA:    sel = MUX_DATA;
      PARITY:  sel = MUX_PAR;
      default: sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Data shift register and bit counter for one frame. Loads on accept, shifts
// right (LSB first) and flags the last data bit.
module uart_tx_shifter
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift,
  input  logic                  first,
  output logic                  bit_out,
  output logic                  last_bit
);

  localparam int CW = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
    end else if (shift) begin
      shreg_d = shreg_q >> 1;
      // The count tracks the data bit now on the line and saturates at the last one.
      if (first) begin
        cnt_d = '0;
      end else if (cnt_q != LAST_CNT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_out  = shreg_q[0];
  assign last_bit = (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// TX_OUT, mux_sel and Busy are registered from the state being entered.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  par_load,
  output logic [1:0]            mux_sel,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e  state_q, state_d;
  logic       par_en_q, par_en_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic [1:0] mux_q, mux_d;

  logic accept;
  logic shift;
  logic first;
  logic bit_out;
  logic last_bit;

  // A request during reset is never accepted, so the parity calculator is left alone.
  assign accept   = Data_Valid & ~RST & ((state_q == IDLE) | (state_q == STOP));
  assign par_load = accept;

  uart_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .load_data(P_DATA),
    .shift    (shift),
    .first    (first),
    .bit_out  (bit_out),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    shift    = 1'b0;
    first    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        state_d = DATA;
        shift   = 1'b1;
        first   = 1'b1;
      end
      DATA: begin
        if (last_bit) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          shift = 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) par_en_d = PAR_EN;

    // Line value for the state being entered; D0 is still at shreg[0] when leaving START.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = bit_out;
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    mux_d  = mux_for_state(state_d);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      mux_q    <= MUX_STOP;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      mux_q    <= mux_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign Busy    = busy_q;
  assign mux_sel = mux_q;

endmodule
